dag_top: RTL
============

DAG_TOP -- requirements
Module: dag_top

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ps_dg_en, input, 1, address-generation request from sequencer (already condition-qualified).
REQ-004 SHALL have port ps_dg_dgsclt, input, 1, destination select: 1 = program-flow address (dg_ps_add), 0 = data-memory address (dg_dm_add).
REQ-005 SHALL have port ps_dg_mdfy, input, 1, 1 = pre-modify (no I update), 0 = post-modify (I updated).
REQ-006 SHALL have ports ps_dg_iadd and ps_dg_madd, input, 3 each, I and M register indices.
REQ-007 SHALL have ports ps_dg_wrt_en (input, 1), ps_dg_wrt_add (input, 5), ps_dg_rd_add (input, 5), ureg write enable, write address, read address.
REQ-008 SHALL have port bc_dt, input, 16, ureg write data from bus connect.
REQ-009 SHALL have ports dg_ps_add and dg_dm_add, output, 16 each, registered generated addresses.
REQ-010 SHALL have port dg_bc_dt, output, 16, ureg read data to bus connect.

Function
REQ-011 SHALL hold four banks of eight 16-bit registers, I0-7, M0-7, L0-7, B0-7; ureg address [4:3] = 00 I, 01 M, 10 L, 11 B; [2:0] = index.
REQ-012 SHALL, on ps_dg_en in cycle N with ps_dg_mdfy=1, present I[iadd]+M[madd] (mod 2^16) on the selected output at edge N+1; I unchanged.
REQ-013 SHALL, on ps_dg_en in cycle N with ps_dg_mdfy=0, present I[iadd] on the selected output at edge N+1 and load I[iadd] with modified value at the same edge.
REQ-014 SHALL treat M as 16-bit two's complement; modified value computed at 17 bits.
REQ-015 SHALL, when L[iadd]=0, use linear modify: new = I+M mod 2^16.
REQ-016 SHALL, when L[iadd]!=0, use circular modify: t = I+M; t >= B+L -> t-L; t < B -> t+L; else t; comparisons unsigned at 17 bits.
REQ-017 SHALL apply circular wrap to post-modify updates only; pre-modify address is linear.
REQ-018 SHALL leave the unselected address output holding its previous value; with ps_dg_en=0 both outputs hold.
REQ-019 SHALL use register contents at start of cycle for generation; a same-cycle ureg write to M/L/B does not affect that generation.
REQ-020 SHALL, on ureg write to I[k] in the same cycle as post-modify of I[k], give the ureg write priority.
REQ-021 SHALL, on ureg write to B[k], also load I[k] with bc_dt at the same edge; higher priority than post-modify of I[k].
REQ-022 SHALL drive dg_bc_dt combinationally from the register at ps_dg_rd_add; if ps_dg_wrt_en and ps_dg_wrt_add==ps_dg_rd_add, drive bc_dt (bypass).
REQ-023 SHALL ignore ureg writes when ps_dg_wrt_en=0.

Reset
REQ-024 SHALL clear all I, M, L, B registers, dg_ps_add and dg_dm_add to 16'h0000 on rst low, asynchronously.
REQ-025 SHALL resume generation on the first edge after rst deasserts; a request in flight at reset is discarded.

Structure
REQ-026 SHALL place bank codes (I=2'b00, M=2'b01, L=2'b10, B=2'b11), register count 8 and data width 16 in shared package dag_pkg.
REQ-027 SHALL implement modify-and-wrap arithmetic (REQ-014 to REQ-016) in one combinational sub-module circ_mdfy; registers and muxing stay in dag_top.

Verification
REQ-028 SHALL check linear post-modify: I0=0x0010, M1=0x0004, L0=0, en, iadd=0, madd=1, mdfy=0, dgsclt=0 -> dg_dm_add=0x0010, I0=0x0014 next edge.
REQ-029 SHALL check circular wrap up: B2=0x0100, L2=0x0008, I2=0x0106, M0=0x0003, post-modify -> dg_dm_add=0x0106, I2=0x0101.
REQ-030 SHALL check circular wrap down: same B2/L2, I2=0x0101, M3=0xFFFD (-3) -> I2=0x0106.
REQ-031 SHALL check pre-modify to sequencer: I5=0x0200, M7=0x0020, mdfy=1, dgsclt=1 -> dg_ps_add=0x0220, I5 stays 0x0200, dg_dm_add unchanged.
REQ-032 SHALL check collision and bypass: ureg write I3=0x0055 same cycle as post-modify of I3 -> I3=0x0055; rd_add=wrt_add=5'b01010 with bc_dt=0x1234 -> dg_bc_dt=0x1234 in that cycle.
REQ-033 SHALL check reset mid-operation: rst low after I0 update -> all registers and both outputs read 0x0000 immediately, before next clock edge.

Source files
------------

// File: rtl/dag_pkg.sv
// dag_pkg: shared constants and types for the data address generator.
//   DW      - register / address width
//   NREG    - registers per bank
//   bank_e  - ureg bank code carried in ureg address bits [4:3]
package dag_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int IW   = 3;   // index width within a bank
  localparam int AW   = 5;   // ureg address width: {bank, index}

  typedef enum logic [1:0] {
    BANK_I = 2'b00,
    BANK_M = 2'b01,
    BANK_L = 2'b10,
    BANK_B = 2'b11
  } bank_e;

endpackage

// File: rtl/dag_if.sv
// dag_if: sequencer request, ureg access and generated-address signals.
//   master - sequencer / bus-connect side (drives requests and ureg traffic)
//   slave  - address generator side (drives generated addresses and read data)
interface dag_if;
  import dag_pkg::*;

  logic          ps_dg_en;
  logic          ps_dg_dgsclt;
  logic          ps_dg_mdfy;
  logic [IW-1:0] ps_dg_iadd;
  logic [IW-1:0] ps_dg_madd;
  logic          ps_dg_wrt_en;
  logic [AW-1:0] ps_dg_wrt_add;
  logic [AW-1:0] ps_dg_rd_add;
  logic [DW-1:0] bc_dt;
  logic [DW-1:0] dg_ps_add;
  logic [DW-1:0] dg_dm_add;
  logic [DW-1:0] dg_bc_dt;

  modport master (
    output ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
    output ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    input  dg_ps_add, dg_dm_add, dg_bc_dt
  );

  modport slave (
    input  ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
    input  ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    output dg_ps_add, dg_dm_add, dg_bc_dt
  );

endinterface

// File: rtl/dag_circ_mdfy.sv
// circ_mdfy: combinational modify-and-wrap arithmetic.
//   i_val, m_val, l_val, b_val - current I, M (two's complement), L, B
//   lin_val                    - I+M mod 2^16 (pre-modify address)
//   post_val                   - next I value: linear when L==0, else circular
module circ_mdfy
  import dag_pkg::*;
(
  input  logic [DW-1:0] i_val,
  input  logic [DW-1:0] m_val,
  input  logic [DW-1:0] l_val,
  input  logic [DW-1:0] b_val,
  output logic [DW-1:0] lin_val,
  output logic [DW-1:0] post_val
);

  logic [DW:0] sum17;
  logic [DW:0] top17;
  logic [DW:0] wrap17;

  // M is sign-extended, I zero-extended; the 17-bit sum feeds unsigned compares.
  assign sum17   = {1'b0, i_val} + {m_val[DW-1], m_val};
  assign top17   = {1'b0, b_val} + {1'b0, l_val};
  assign lin_val = sum17[DW-1:0];

  always_comb begin
    wrap17 = sum17;
    if (sum17 >= top17)
      wrap17 = sum17 - {1'b0, l_val};
    else if (sum17 < {1'b0, b_val})
      wrap17 = sum17 + {1'b0, l_val};
  end

  assign post_val = (l_val == '0) ? lin_val : wrap17[DW-1:0];

endmodule

// File: rtl/dag_top.sv
// dag_top: data address generator with I/M/L/B register banks.
//   clk, rst - clock, asynchronous active-low reset
//   bus      - dag_if.slave: sequencer request (en/dgsclt/mdfy/iadd/madd),
//              ureg write/read (wrt_en/wrt_add/rd_add/bc_dt), registered
//              addresses dg_ps_add/dg_dm_add, combinational read dg_bc_dt
module dag_top
  import dag_pkg::*;
(
  input  logic clk,
  input  logic rst,
  dag_if.slave bus
);

  logic [DW-1:0] i_reg [NREG];
  logic [DW-1:0] m_reg [NREG];
  logic [DW-1:0] l_reg [NREG];
  logic [DW-1:0] b_reg [NREG];

  logic [DW-1:0] lin_val;
  logic [DW-1:0] post_val;
  logic [DW-1:0] gen_addr;
  bank_e         wr_bank;
  bank_e         rd_bank;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_bank = bank_e'(bus.ps_dg_wrt_add[AW-1:IW]);
  assign wr_idx  = bus.ps_dg_wrt_add[IW-1:0];
  assign rd_bank = bank_e'(bus.ps_dg_rd_add[AW-1:IW]);
  assign rd_idx  = bus.ps_dg_rd_add[IW-1:0];

  circ_mdfy u_circ_mdfy (
    .i_val    (i_reg[bus.ps_dg_iadd]),
    .m_val    (m_reg[bus.ps_dg_madd]),
    .l_val    (l_reg[bus.ps_dg_iadd]),
    .b_val    (b_reg[bus.ps_dg_iadd]),
    .lin_val  (lin_val),
    .post_val (post_val)
  );

  // Pre-modify emits the linear sum; post-modify emits the current I.
  assign gen_addr = bus.ps_dg_mdfy ? lin_val : i_reg[bus.ps_dg_iadd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      bus.dg_ps_add <= '0;
      bus.dg_dm_add <= '0;
    end else begin
      if (bus.ps_dg_en) begin
        if (bus.ps_dg_dgsclt)
          bus.dg_ps_add <= gen_addr;
        else
          bus.dg_dm_add <= gen_addr;
        if (!bus.ps_dg_mdfy)
          i_reg[bus.ps_dg_iadd] <= post_val;
      end
      // Placed after the post-modify update so a ureg write to I[k] or B[k]
      // overrides a same-edge post-modify of I[k].
      if (bus.ps_dg_wrt_en) begin
        unique case (wr_bank)
          BANK_I: i_reg[wr_idx] <= bus.bc_dt;
          BANK_M: m_reg[wr_idx] <= bus.bc_dt;
          BANK_L: l_reg[wr_idx] <= bus.bc_dt;
          BANK_B: begin
            b_reg[wr_idx] <= bus.bc_dt;
            i_reg[wr_idx] <= bus.bc_dt;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.dg_bc_dt = '0;
    unique case (rd_bank)
      BANK_I: bus.dg_bc_dt = i_reg[rd_idx];
      BANK_M: bus.dg_bc_dt = m_reg[rd_idx];
      BANK_L: bus.dg_bc_dt = l_reg[rd_idx];
      BANK_B: bus.dg_bc_dt = b_reg[rd_idx];
    endcase
    // Write-through bypass so a reader sees data being written this cycle.
    if (bus.ps_dg_wrt_en && (bus.ps_dg_wrt_add == bus.ps_dg_rd_add))
      bus.dg_bc_dt = bus.bc_dt;
  end

endmodule
